// File: rtl/music_sequencer.sv
// Song sequencer: walks a note ROM at beat rate, owns volume/mute.
// Define MUSIC_SEQUENCER_LOOP_EN to replay the song instead of stopping.
module music_sequencer #(
  parameter int CLK_HZ   = 100000000,
  parameter int BEAT_HZ  = 8,
  parameter int SONG_LEN = 64,
  parameter int GAP_CYC  = 200000,
  parameter int VOL_MAX  = 5
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [1:0]                      song_sel,
  input  logic                            vol_up,
  input  logic                            vol_down,
  input  logic                            mute,
  output logic [$clog2(SONG_LEN)+1:0]     rom_addr,
  input  logic [7:0]                      rom_data,
  output logic [5:0]                      tone_code,
  output logic                            tone_valid,
  output logic [2:0]                      volume,
  output logic [15:0]                     amp,
  output logic                            busy,
  output logic                            song_done
);

  localparam int BEAT_DIV = CLK_HZ / BEAT_HZ;
  localparam int IW = $clog2(SONG_LEN);
  localparam int CMAX = (BEAT_DIV > GAP_CYC) ? BEAT_DIV : GAP_CYC;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(SONG_LEN - 1);
  localparam logic [5:0]    END_CODE  = 6'h3F;
  localparam logic [2:0]    VOL_TOP   = 3'(VOL_MAX);
  localparam logic [2:0]    VOL_RST   = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    PLAY,
    GAP
  } state_t;

  state_t        state;
  logic [1:0]    sel;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_next;
  logic [CW-1:0] cnt;
  logic [1:0]    beats;
  logic [1:0]    len;
  logic          restart;
  logic          song_end;

  assign idx_next = idx + IW'(1);

  // Any start or song change while active rewinds to note 0.
  assign restart = (state != IDLE) &&
                   (start || (song_sel != sel));

  // End marker read, or the last slot of the song finished its gap.
  assign song_end =
    ((state == WAIT) && (rom_data[5:0] == END_CODE)) ||
    ((state == GAP) && (cnt == GAP_LAST) &&
     (idx == IDX_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sel        <= 2'd0;
      idx        <= '0;
      cnt        <= '0;
      beats      <= 2'd0;
      len        <= 2'd0;
      rom_addr   <= '0;
      tone_code  <= 6'd0;
      tone_valid <= 1'b0;
      busy       <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      song_done <= 1'b0;
      if (restart || (state == IDLE && start)) begin
        state      <= FETCH;
        sel        <= song_sel;
        idx        <= '0;
        cnt        <= '0;
        beats      <= 2'd0;
        rom_addr   <= {song_sel, {IW{1'b0}}};
        tone_valid <= 1'b0;
        busy       <= 1'b1;
      end else if (song_end) begin
        song_done  <= 1'b1;
        tone_valid <= 1'b0;
        cnt        <= '0;
`ifdef MUSIC_SEQUENCER_LOOP_EN
        state      <= FETCH;
        idx        <= '0;
        rom_addr   <= {sel, {IW{1'b0}}};
`else
        state      <= IDLE;
        busy       <= 1'b0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
          end
          FETCH: begin
            state <= WAIT;
          end
          WAIT: begin
            tone_code  <= rom_data[5:0];
            tone_valid <= |rom_data[5:0];
            len        <= rom_data[7:6];
            cnt        <= '0;
            beats      <= 2'd0;
            state      <= PLAY;
          end
          PLAY: begin
            if (cnt == BEAT_LAST) begin
              cnt <= '0;
              if (beats == len) begin
                state      <= GAP;
                tone_valid <= 1'b0;
              end else begin
                beats <= beats + 2'd1;
              end
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          GAP: begin
            if (cnt == GAP_LAST) begin
              cnt      <= '0;
              idx      <= idx_next;
              rom_addr <= {sel, idx_next};
              state    <= FETCH;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      volume <= VOL_RST;
    end else begin
      unique case (1'b1)
        (vol_up & ~vol_down): begin
          if (volume < VOL_TOP)
            volume <= volume + 3'd1;
        end
        (vol_down & ~vol_up): begin
          if (volume != 3'd0)
            volume <= volume - 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign amp = mute ? 16'h0000 : {1'b0, volume, 12'h000};

endmodule
